// File: rtl/tone_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tone_decoder                                                 |
// | Description : Recovers a note index (C4..D6, 0..15) from a square-wave     |
// |               tone by measuring its half-period and scanning a 16-entry    |
// |               table one entry per cycle. A note is declared only after     |
// |               STABLE_CNT consecutive identical matches.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1  system clock                                          |
// |   rst        in   1  asynchronous active-low reset                         |
// |   tone_in    in   1  asynchronous square wave                              |
// |   note       out  4  decoded note index (0=C4 .. 15=D6)                    |
// |   note_valid out  1  high while a stable, in-table tone is present         |
// |   note_pulse out  1  1-cycle strobe on valid rise or note change           |
// +----------------------------------------------------------------------------+
module tone_decoder #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int CNT_W       = 18,
   parameter int TOL_SHIFT   = 5,
   parameter int STABLE_CNT  = 4,
   parameter int TIMEOUT_CYC = 250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tone_in,
   output logic [3:0] note,
   output logic       note_valid,
   output logic       note_pulse
);

   localparam int STB_W = $clog2(STABLE_CNT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_RESULT = 2'd2;

   localparam logic [CNT_W-1:0] C_TIMEOUT    = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [STB_W-1:0] C_STB_MAX    = STB_W'(STABLE_CNT);
   localparam logic [3:0]       C_LAST_IDX   = 4'd15;

   // Note frequencies in Hz (integer), C4..D6.
   localparam int FREQ_HZ [16] = '{261, 293, 329, 349, 392, 440, 493, 523,
                                   587, 659, 698, 784, 880, 987, 1046, 1174};

   // Nominal half-period table, folded to constants at elaboration.
   logic [CNT_W-1:0] table_w [16];
   for (genvar gi = 0; gi < 16; gi++) begin : g_table
      assign table_w[gi] = CNT_W'(CLK_HZ / FREQ_HZ[gi] / 2);
   end

   logic             sync1_q, sync2_q, level_q;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] meas_q, meas_d;
   logic             first_edge_q, first_edge_d;
   logic [1:0]       state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic             found_q, found_d;
   logic [3:0]       res_q, res_d;
   logic [3:0]       cand_q, cand_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic [3:0]       note_q, note_d;
   logic             note_valid_q, note_valid_d;
   logic             note_pulse_q, note_pulse_d;

   logic             edge_w, timeout_w, hit_w, fin_found_w;
   logic [3:0]       fin_idx_w;
   logic [CNT_W:0]   meas_x, nom_x, diff_w, tol_w;

   assign edge_w = sync2_q ^ level_q;

   // Window compare one bit wider than the counter so the difference never wraps.
   assign meas_x = {1'b0, meas_q};
   assign nom_x  = {1'b0, table_w[idx_q]};
   assign tol_w  = nom_x >> TOL_SHIFT;
   assign diff_w = (meas_x >= nom_x) ? (meas_x - nom_x) : (nom_x - meas_x);
   assign hit_w  = (diff_w <= tol_w);

   // Final scan outcome including the comparison made in the last scan cycle.
   assign fin_found_w = found_q | hit_w;
   assign fin_idx_w   = found_q ? res_q : idx_q;

   // Saturation is reached on the cycle after this, so timeout fires once.
   assign timeout_w = !edge_w && (period_cnt_q == C_TIMEOUT_M1);

   always_comb begin
      period_cnt_d = period_cnt_q;
      meas_d       = meas_q;
      first_edge_d = first_edge_q;
      state_d      = state_q;
      idx_d        = idx_q;
      found_d      = found_q;
      res_d        = res_q;
      cand_d       = cand_q;
      stable_d     = stable_q;
      note_d       = note_q;
      note_valid_d = note_valid_q;
      note_pulse_d = 1'b0;

      if (edge_w) begin
         period_cnt_d = '0;
         if (first_edge_q) begin
            // Nothing meaningful to measure yet; just start timing.
            first_edge_d = 1'b0;
         end else begin
            // Starts (or aborts and restarts) the scan with the new period.
            meas_d  = period_cnt_q + 1'b1;
            state_d = S_SCAN;
            idx_d   = 4'd0;
            found_d = 1'b0;
         end
      end else begin
         if (period_cnt_q != C_TIMEOUT) begin
            period_cnt_d = period_cnt_q + 1'b1;
         end

         if (timeout_w) begin
            note_valid_d = 1'b0;
            stable_d     = '0;
            state_d      = S_IDLE;
            first_edge_d = 1'b1;
         end else begin
            case (state_q)
               S_SCAN: begin
                  if (!found_q && hit_w) begin
                     found_d = 1'b1;
                     res_d   = idx_q;
                  end
                  if (idx_q == C_LAST_IDX) begin
                     // Commit here so registered outputs appear in the RESULT cycle.
                     state_d = S_RESULT;
                     if (!fin_found_w) begin
                        stable_d     = '0;
                        note_valid_d = 1'b0;
                     end else if (fin_idx_w == cand_q) begin
                        stable_d = (stable_q >= C_STB_MAX) ? C_STB_MAX : stable_q + 1'b1;
                     end else begin
                        cand_d   = fin_idx_w;
                        stable_d = STB_W'(1);
                     end
                     if ((stable_d == C_STB_MAX) && (!note_valid_q || (cand_d != note_q))) begin
                        note_d       = cand_d;
                        note_valid_d = 1'b1;
                        note_pulse_d = 1'b1;
                     end
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
               S_RESULT: state_d = S_IDLE;
               default:  state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         period_cnt_q <= '0;
         meas_q       <= '0;
         first_edge_q <= 1'b1;
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         found_q      <= 1'b0;
         res_q        <= 4'd0;
         cand_q       <= 4'd0;
         stable_q     <= '0;
         note_q       <= 4'd0;
         note_valid_q <= 1'b0;
         note_pulse_q <= 1'b0;
      end else begin
         sync1_q      <= tone_in;
         sync2_q      <= sync1_q;
         level_q      <= sync2_q;
         period_cnt_q <= period_cnt_d;
         meas_q       <= meas_d;
         first_edge_q <= first_edge_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         found_q      <= found_d;
         res_q        <= res_d;
         cand_q       <= cand_d;
         stable_q     <= stable_d;
         note_q       <= note_d;
         note_valid_q <= note_valid_d;
         note_pulse_q <= note_pulse_d;
      end
   end

   assign note       = note_q;
   assign note_valid = note_valid_q;
   assign note_pulse = note_pulse_q;

endmodule
`default_nettype wire
